// File: rtl/bce_vec_if.sv
// Bus bundle for the bit-column engine: the input beat channel (valid/ready plus
// payload) and the result channel (valid/ready plus result and saturation flag).
// The master modport is the producer/consumer side; the engine uses slave.
interface bce_vec_if #(
    parameter int LANES   = 8,
    parameter int ACT_W   = 8,
    parameter int SHIFT_W = 3,
    parameter int ACC_W   = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_sign_ld;
    logic [LANES*ACT_W-1:0]   act;
    logic [LANES-1:0]         wcol;
    logic [SHIFT_W-1:0]       shift_off;
    logic                     last;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_W-1:0]         out_result;
    logic                     out_sat;

    modport master (
        output in_valid, in_sign_ld, act, wcol, shift_off, last, out_ready,
        input  in_ready, out_valid, out_result, out_sat
    );

    modport slave (
        input  in_valid, in_sign_ld, act, wcol, shift_off, last, out_ready,
        output in_ready, out_valid, out_result, out_sat
    );
endinterface

// File: rtl/bce_vec_engine.sv
// Bit-column engine: LANES signed activations times one weight bit-column per beat,
// per-lane weight sign, adder-tree partial sum, shifted by the column's bit position
// and accumulated until the beat marked last. Three enabled pipeline stages
// (capture, lane products, shifted term) feed the accumulator/result register.
// The whole pipeline freezes while a result is waiting on the consumer.
// Optional feature macro: BCE_SAT_EN (saturating accumulate + sticky out_sat).
module bce_vec_engine #(
    parameter int LANES   = 8,
    parameter int ACT_W   = 8,
    parameter int SHIFT_W = 3,
    parameter int ACC_W   = 16
) (
    input logic      clk,
    input logic      rst,
    bce_vec_if.slave bus
);
    localparam int PSUM_W = ACT_W + 1 + $clog2(LANES);
`ifdef BCE_SAT_EN
    // Wide enough that a shifted term plus the accumulator never wraps before clamping.
    localparam int TERM_W = ACC_W + PSUM_W + (1 << SHIFT_W);
    localparam logic signed [TERM_W-1:0] SAT_MAX = {{(TERM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [TERM_W-1:0] SAT_MIN = {{(TERM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
`else
    localparam int TERM_W = ACC_W;
`endif

    logic                      stall;
    logic                      en;
    logic                      accept;
    logic [LANES-1:0]          sign_reg;

    logic                      s1_v;
    logic                      s1_last;
    logic [LANES*ACT_W-1:0]    s1_act;
    logic [LANES-1:0]          s1_wcol;
    logic [LANES-1:0]          s1_sign;
    logic [SHIFT_W-1:0]        s1_shift;

    logic signed [ACT_W:0]     prod_d [LANES];
    logic                      s2_v;
    logic                      s2_last;
    logic signed [ACT_W:0]     s2_prod [LANES];
    logic [SHIFT_W-1:0]        s2_shift;

    logic signed [PSUM_W-1:0]  psum_d;
    logic signed [TERM_W-1:0]  term_d;
    logic                      s3_v;
    logic                      s3_last;
    logic signed [TERM_W-1:0]  s3_term;

    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic signed [ACC_W-1:0]   out_result_q;
    logic                      out_valid_q;
`ifdef BCE_SAT_EN
    logic signed [TERM_W-1:0]  sum_w;
    logic                      clamp_d;
    logic                      acc_sat_q;
    logic                      out_sat_q;
`endif

    // One extra bit so negating the most negative activation cannot overflow.
    function automatic logic signed [ACT_W:0] lane_prod(input logic [ACT_W-1:0] a,
                                                        input logic w,
                                                        input logic s);
        logic signed [ACT_W:0] ext;
        ext = $signed({a[ACT_W-1], a});
        if (!w) return '0;
        return s ? -ext : ext;
    endfunction

    assign stall         = out_valid_q && !bus.out_ready;
    assign en            = !stall;
    assign accept        = bus.in_valid && en;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_result = out_result_q;
`ifdef BCE_SAT_EN
    assign bus.out_sat   = out_sat_q;
`else
    assign bus.out_sat   = 1'b0;
`endif

    // Capture stage: beat payload plus a snapshot of the sign register; sign loads only update the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_reg <= '0;
            s1_v     <= 1'b0;
            s1_last  <= 1'b0;
            s1_act   <= '0;
            s1_wcol  <= '0;
            s1_sign  <= '0;
            s1_shift <= '0;
        end else if (en) begin
            s1_v <= accept && !bus.in_sign_ld;
            if (accept && bus.in_sign_ld) begin
                sign_reg <= bus.wcol;
            end
            if (accept && !bus.in_sign_ld) begin
                s1_act   <= bus.act;
                s1_wcol  <= bus.wcol;
                s1_sign  <= sign_reg;
                s1_shift <= bus.shift_off;
                s1_last  <= bus.last;
            end
        end
    end

    // Per-lane signed product of activation and weight bit.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = lane_prod(s1_act[i*ACT_W +: ACT_W], s1_wcol[i], s1_sign[i]);
        end
    end

    // Product stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v     <= 1'b0;
            s2_last  <= 1'b0;
            s2_shift <= '0;
            s2_prod  <= '{default: '0};
        end else if (en) begin
            s2_v     <= s1_v;
            s2_last  <= s1_last;
            s2_shift <= s1_shift;
            s2_prod  <= prod_d;
        end
    end

    // Adder tree and bit-position shift of the partial sum.
    always_comb begin
        psum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            psum_d = psum_d + PSUM_W'(s2_prod[i]);
        end
        term_d = TERM_W'(psum_d) <<< s2_shift;
    end

    // Term stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s3_v    <= 1'b0;
            s3_last <= 1'b0;
            s3_term <= '0;
        end else if (en) begin
            s3_v    <= s2_v;
            s3_last <= s2_last;
            s3_term <= term_d;
        end
    end

`ifdef BCE_SAT_EN
    // Accumulate at full precision, then clamp into the result range.
    always_comb begin
        sum_w   = TERM_W'(acc_q) + s3_term;
        clamp_d = 1'b0;
        acc_nxt = sum_w[ACC_W-1:0];
        if (sum_w > SAT_MAX) begin
            acc_nxt = SAT_MAX[ACC_W-1:0];
            clamp_d = 1'b1;
        end else if (sum_w < SAT_MIN) begin
            acc_nxt = SAT_MIN[ACC_W-1:0];
            clamp_d = 1'b1;
        end
    end
`else
    // Plain two's-complement accumulate, wrapping at ACC_W bits.
    always_comb begin
        acc_nxt = acc_q + s3_term;
    end
`endif

    // Accumulator and result register; a new result may replace one being taken in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
`ifdef BCE_SAT_EN
            acc_sat_q    <= 1'b0;
            out_sat_q    <= 1'b0;
`endif
        end else if (en) begin
            out_valid_q <= 1'b0;
            if (s3_v) begin
                if (s3_last) begin
                    out_result_q <= acc_nxt;
                    out_valid_q  <= 1'b1;
                    acc_q        <= '0;
`ifdef BCE_SAT_EN
                    out_sat_q    <= acc_sat_q | clamp_d;
                    acc_sat_q    <= 1'b0;
`endif
                end else begin
                    acc_q        <= acc_nxt;
`ifdef BCE_SAT_EN
                    acc_sat_q    <= acc_sat_q | clamp_d;
`endif
                end
            end
        end
    end
endmodule
